actuator_sequencer: RTL and testbench
=====================================

# actuator_sequencer

Parametrised command sequencer between the SPI command register and the actuator memory and update engine. A latched command word can start a single or burst memory access (read, or write-fill with auto-incrementing address). It can also load a system mode: off, periodic refresh, triggered, or single-shot. The block drives the update-engine enable from that mode and generates a programmable-width trigger-out pulse on each update completion.

## Interface
Parameters:
- DATA_W, 16, memory data width
- ADDR_W, 8, memory address width
- CNT_W, 32, refresh counter width
- TRIG_PULSE, 2, trigger_out_n low width in cycles (>=1)
- CMD_W (local), 8+ADDR_W+DATA_W

Ports:
- clock  in  1  single system clock
- reset_n  in  1  synchronous, active-low reset
- latch_data_sn  in  1  active-low command strobe, pre-synchronised
- cmd_word  in  CMD_W  {opcode[7:0], address, data}
- refresh_period  in  CNT_W  idle cycles between refresh updates
- update_done  in  1  update engine finished (level, sampled)
- trigger_in_sn  in  1  active-low external trigger, pre-synchronised
- memory_data_in  in  DATA_W  memory read data, valid the cycle after strobe
- memory_enable_n / memory_write_n / memory_read_n  out  1 each  memory strobes
- memory_address  out  ADDR_W  current access address
- memory_data_out  out  DATA_W  write data
- memory_data  out  DATA_W  last captured read word
- data_valid_n  out  1  one-cycle low per captured read word
- system_enable_n  out  1  low while update engine runs
- trigger_out_n  out  1  update-complete pulse
- busy_n  out  1  low while memory engine active
- cmd_error_n  out  1  one-cycle low when a command is dropped
- control_state  out  8  opcode of last accepted command

## Operation
- Opcode fields:
  - [1:0] memory op: 00 none, 01 read, 10 write-fill, 11 reserved (no access).
  - [3:2] mode: 00 OFF, 01 REFRESH, 10 TRIGGERED, 11 SINGLE.
  - [4] mode_load.
  - [7:5] burst length minus 1, giving 1..8 words.
- Command edge: latch_data_sn sampled low with previous sample high. The previous-sample register resets to 0, so a strobe already held low at reset release is not a command.
- Accept/drop:
  - Accepted if busy_n is high: the opcode, address and data registers load.
  - Dropped if busy_n is low: registers are unchanged and cmd_error_n pulses.
- Memory engine states: IDLE, ACCESS, WAIT, VALID.
  - Read word: ACCESS (enable_n=read_n=0), then WAIT (memory_data_in captured at end of WAIT), then VALID (data_valid_n=0). 3 cycles per word.
  - Write word: ACCESS (enable_n=write_n=0, memory_data_out=data), then WAIT. 2 cycles per word.
  - After each word the address increments modulo 2^ADDR_W; 8'hFF-style wrap goes to 0.
- memory_address and memory_data_out are registered and hold their values after the op completes.
- System FSM states: IDLE, RUN, WAIT, DONE. system_enable_n is low only in RUN.
  - OFF: stays in IDLE.
  - REFRESH: IDLE→RUN; RUN→WAIT on update_done; WAIT counts from 0 and goes to RUN when count >= refresh_period.
  - TRIGGERED: IDLE→RUN on trigger_in_sn low; RUN→WAIT on update_done; WAIT→IDLE when trigger_in_sn is high (re-arm).
  - SINGLE: IDLE→RUN; RUN→DONE on update_done; DONE is held until the next mode load.
- update_done is ignored outside RUN.
- A RUN→(WAIT|DONE) transition starts a trigger_out_n low pulse of TRIG_PULSE cycles. A new completion during a pulse restarts the pulse count.
- An accepted command with mode_load=1 forces the system FSM to IDLE, clears the refresh counter and latches the new mode. This takes priority over a simultaneous update_done: no transition and no trigger pulse.
- A memory-op-only command leaves the system FSM untouched.

## Timing
- Reset (reset_n low at an edge) sets:
  - all *_n outputs high;
  - memory_address, memory_data_out, memory_data, control_state, refresh counter all 0;
  - both FSMs IDLE, mode OFF.
- Reset mid-burst or mid-pulse aborts it immediately. There are no further strobes.
- Edge sampled in cycle N:
  - registers load at end of N; control_state updates in N+1;
  - first ACCESS is in N+1, with busy_n low from N+1;
  - read: data_valid_n low in N+3, next strobe in N+4;
  - write: next strobe in N+3.
- busy_n returns high the cycle after the final word's last state. An edge in that first busy_n-high cycle is accepted.
- Mode load at N: FSM is IDLE in N+1. In REFRESH/SINGLE, RUN begins at N+2.
- update_done sampled in RUN at cycle M: system_enable_n high in M+1; trigger_out_n low M+1..M+TRIG_PULSE.
- refresh_period=0: WAIT lasts 1 cycle.

## Test plan
- Read burst: opcode 8'h21 (2 words), addr 8'hFF, memory_data_in = address-driven → strobes at addresses FF then 00, data_valid_n lows 3 cycles apart, memory_data = last word, busy_n low 6 cycles.
- Write fill: opcode 8'h42 (3 words), addr 8'h10, data 16'hBEEF → write_n low at addresses 10, 11, 12 every 2nd cycle, data_out constant BEEF.
- Command dropped: second strobe edge 1 cycle into a read → cmd_error_n low 1 cycle, control_state unchanged, first read completes normally.
- Refresh: opcode 8'h14, refresh_period=5, update_done 3 cycles after each RUN entry → each RUN→RUN interval = 3+1+6 cycles, trigger_out_n low 2 cycles per completion.
- Triggered + mode priority: opcode 8'h18, trigger_in_sn pulsed low → one RUN; held low → no re-run until released. A mode load in the same cycle as update_done → no trigger_out.
- Reset: reset_n low mid-burst → all strobes high next cycle, memory_data 0, busy_n high.

Source files
------------

// File: rtl/actuator_sequencer_if.sv
// Memory-side bus between the actuator sequencer and the actuator memory.
// The sequencer is the master; the memory model or device is the slave.
interface actuator_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic              memory_enable_n;
  logic              memory_write_n;
  logic              memory_read_n;
  logic [ADDR_W-1:0] memory_address;
  logic [DATA_W-1:0] memory_data_out;
  logic [DATA_W-1:0] memory_data_in;

  modport master (
    output memory_enable_n, memory_write_n, memory_read_n,
    output memory_address, memory_data_out,
    input  memory_data_in
  );

  modport slave (
    input  memory_enable_n, memory_write_n, memory_read_n,
    input  memory_address, memory_data_out,
    output memory_data_in
  );
endinterface

// File: rtl/actuator_sequencer.sv
// Command sequencer: decodes latched SPI command words into single/burst memory
// accesses and update-engine mode control with a trigger-out completion pulse.
module actuator_sequencer #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 8,
  parameter int CNT_W      = 32,
  parameter int TRIG_PULSE = 2
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       latch_data_sn,
  input  logic [8+ADDR_W+DATA_W-1:0] cmd_word,
  input  logic [CNT_W-1:0]           refresh_period,
  input  logic                       update_done,
  input  logic                       trigger_in_sn,
  actuator_sequencer_if.master       mem_bus,
  output logic [DATA_W-1:0]          memory_data,
  output logic                       data_valid_n,
  output logic                       system_enable_n,
  output logic                       trigger_out_n,
  output logic                       busy_n,
  output logic                       cmd_error_n,
  output logic [7:0]                 control_state
);
  localparam int CMD_W  = 8 + ADDR_W + DATA_W;
  localparam int TRIG_W = $clog2(TRIG_PULSE + 1);

  localparam logic [1:0] OP_READ      = 2'b01;
  localparam logic [1:0] OP_WRITE     = 2'b10;
  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_REFRESH = 2'b01;
  localparam logic [1:0] MODE_TRIG    = 2'b10;
  localparam logic [1:0] MODE_SINGLE  = 2'b11;

  typedef enum logic [1:0] {MEM_IDLE, MEM_ACCESS, MEM_WAIT, MEM_VALID} mem_state_t;
  typedef enum logic [1:0] {SYS_IDLE, SYS_RUN, SYS_WAIT, SYS_DONE} sys_state_t;

  mem_state_t        mem_state_r, mem_next_s;
  sys_state_t        sys_state_r, sys_next_s;

  logic              latch_prev_r;
  logic [7:0]        control_state_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] rdata_r;
  logic              rd_op_r;
  logic [2:0]        words_left_r;
  logic              mem_enable_n_r, mem_read_n_r, mem_write_n_r;
  logic              data_valid_n_r, busy_n_r, cmd_error_n_r;
  logic [1:0]        mode_r;
  logic [CNT_W-1:0]  refresh_cnt_r;
  logic              system_enable_n_r, trigger_out_n_r;
  logic [TRIG_W-1:0] trig_cnt_r;

  logic [7:0]        cmd_opcode_s;
  logic [ADDR_W-1:0] cmd_addr_s;
  logic [DATA_W-1:0] cmd_data_s;
  logic              cmd_edge_s, accept_s, drop_s, mode_load_s, start_op_s;
  logic              op_is_read_s, next_word_s, completion_s;

  assign cmd_opcode_s = cmd_word[CMD_W-1 -: 8];
  assign cmd_addr_s   = cmd_word[DATA_W +: ADDR_W];
  assign cmd_data_s   = cmd_word[DATA_W-1:0];

  // The previous-sample register resets low, so a strobe held low through reset is ignored.
  assign cmd_edge_s   = latch_prev_r & ~latch_data_sn;
  assign accept_s     = cmd_edge_s & busy_n_r;
  assign drop_s       = cmd_edge_s & ~busy_n_r;
  assign mode_load_s  = accept_s & cmd_opcode_s[4];
  assign start_op_s   = accept_s & ((cmd_opcode_s[1:0] == OP_READ) | (cmd_opcode_s[1:0] == OP_WRITE));
  assign op_is_read_s = start_op_s ? (cmd_opcode_s[1:0] == OP_READ) : rd_op_r;
  assign next_word_s  = (mem_state_r != MEM_IDLE) && (mem_next_s == MEM_ACCESS);

  // Memory engine next-state logic.
  always_comb begin
    mem_next_s = mem_state_r;
    case (mem_state_r)
      MEM_IDLE: begin
        if (start_op_s) mem_next_s = MEM_ACCESS;
        else            mem_next_s = MEM_IDLE;
      end
      MEM_ACCESS: mem_next_s = MEM_WAIT;
      MEM_WAIT: begin
        if (rd_op_r)                    mem_next_s = MEM_VALID;
        else if (words_left_r != 3'd0)  mem_next_s = MEM_ACCESS;
        else                            mem_next_s = MEM_IDLE;
      end
      MEM_VALID: begin
        if (words_left_r != 3'd0) mem_next_s = MEM_ACCESS;
        else                      mem_next_s = MEM_IDLE;
      end
      default: mem_next_s = MEM_IDLE;
    endcase
  end

  // Memory engine state, command registers and strobes registered from the next state.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      mem_state_r     <= MEM_IDLE;
      latch_prev_r    <= 1'b0;
      control_state_r <= 8'h00;
      addr_r          <= {ADDR_W{1'b0}};
      wdata_r         <= {DATA_W{1'b0}};
      rdata_r         <= {DATA_W{1'b0}};
      rd_op_r         <= 1'b0;
      words_left_r    <= 3'd0;
      mem_enable_n_r  <= 1'b1;
      mem_read_n_r    <= 1'b1;
      mem_write_n_r   <= 1'b1;
      data_valid_n_r  <= 1'b1;
      busy_n_r        <= 1'b1;
      cmd_error_n_r   <= 1'b1;
    end else begin
      mem_state_r    <= mem_next_s;
      latch_prev_r   <= latch_data_sn;
      mem_enable_n_r <= (mem_next_s != MEM_ACCESS);
      mem_read_n_r   <= !((mem_next_s == MEM_ACCESS) && op_is_read_s);
      mem_write_n_r  <= !((mem_next_s == MEM_ACCESS) && !op_is_read_s);
      data_valid_n_r <= (mem_next_s != MEM_VALID);
      busy_n_r       <= (mem_next_s == MEM_IDLE);
      cmd_error_n_r  <= !drop_s;
      if (accept_s) begin
        control_state_r <= cmd_opcode_s;
        addr_r          <= cmd_addr_s;
        wdata_r         <= cmd_data_s;
        rd_op_r         <= (cmd_opcode_s[1:0] == OP_READ);
        words_left_r    <= cmd_opcode_s[7:5];
      end else if (next_word_s) begin
        addr_r       <= addr_r + ADDR_W'(1);
        words_left_r <= words_left_r - 3'd1;
      end
      if ((mem_state_r == MEM_WAIT) && rd_op_r) begin
        rdata_r <= mem_bus.memory_data_in;
      end
    end
  end

  // System FSM next-state; a mode load overrides any completion in the same cycle.
  always_comb begin
    sys_next_s   = sys_state_r;
    completion_s = 1'b0;
    if (mode_load_s) begin
      sys_next_s = SYS_IDLE;
    end else begin
      case (sys_state_r)
        SYS_IDLE: begin
          case (mode_r)
            MODE_REFRESH: sys_next_s = SYS_RUN;
            MODE_SINGLE:  sys_next_s = SYS_RUN;
            MODE_TRIG: begin
              if (!trigger_in_sn) sys_next_s = SYS_RUN;
              else                sys_next_s = SYS_IDLE;
            end
            default: sys_next_s = SYS_IDLE;
          endcase
        end
        SYS_RUN: begin
          if (update_done) begin
            completion_s = 1'b1;
            if (mode_r == MODE_SINGLE) sys_next_s = SYS_DONE;
            else                       sys_next_s = SYS_WAIT;
          end else begin
            sys_next_s = SYS_RUN;
          end
        end
        SYS_WAIT: begin
          case (mode_r)
            MODE_REFRESH: begin
              if (refresh_cnt_r >= refresh_period) sys_next_s = SYS_RUN;
              else                                 sys_next_s = SYS_WAIT;
            end
            MODE_TRIG: begin
              if (trigger_in_sn) sys_next_s = SYS_IDLE;
              else               sys_next_s = SYS_WAIT;
            end
            default: sys_next_s = SYS_IDLE;
          endcase
        end
        SYS_DONE: sys_next_s = SYS_DONE;
        default:  sys_next_s = SYS_IDLE;
      endcase
    end
  end

  // System FSM state, mode, refresh counter and trigger-out pulse stretcher.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sys_state_r       <= SYS_IDLE;
      mode_r            <= MODE_OFF;
      refresh_cnt_r     <= {CNT_W{1'b0}};
      system_enable_n_r <= 1'b1;
      trigger_out_n_r   <= 1'b1;
      trig_cnt_r        <= {TRIG_W{1'b0}};
    end else begin
      sys_state_r       <= sys_next_s;
      system_enable_n_r <= (sys_next_s != SYS_RUN);
      if (mode_load_s) begin
        mode_r        <= cmd_opcode_s[3:2];
        refresh_cnt_r <= {CNT_W{1'b0}};
      end else if (completion_s) begin
        refresh_cnt_r <= {CNT_W{1'b0}};
      end else if (sys_state_r == SYS_WAIT) begin
        refresh_cnt_r <= refresh_cnt_r + CNT_W'(1);
      end
      // A fresh completion reloads the counter, restarting any pulse in flight.
      if (completion_s) begin
        trig_cnt_r <= TRIG_W'(TRIG_PULSE);
      end else if (trig_cnt_r != {TRIG_W{1'b0}}) begin
        trig_cnt_r <= trig_cnt_r - TRIG_W'(1);
      end
      trigger_out_n_r <= !(completion_s || (trig_cnt_r > TRIG_W'(1)));
    end
  end

  assign mem_bus.memory_enable_n = mem_enable_n_r;
  assign mem_bus.memory_write_n  = mem_write_n_r;
  assign mem_bus.memory_read_n   = mem_read_n_r;
  assign mem_bus.memory_address  = addr_r;
  assign mem_bus.memory_data_out = wdata_r;
  assign memory_data             = rdata_r;
  assign data_valid_n            = data_valid_n_r;
  assign system_enable_n         = system_enable_n_r;
  assign trigger_out_n           = trigger_out_n_r;
  assign busy_n                  = busy_n_r;
  assign cmd_error_n             = cmd_error_n_r;
  assign control_state           = control_state_r;
endmodule

// File: tb/tb_actuator_sequencer.sv
// Directed bench for actuator_sequencer: memory bursts, command drop, system modes,
// trigger-out pulse and reset behaviour, with hand-computed expectations.
module tb_actuator_sequencer;
  logic        clock;
  logic        reset_n;
  logic        latch_data_sn;
  logic [31:0] cmd_word;
  logic [31:0] refresh_period;
  logic        update_done;
  logic        trigger_in_sn;
  logic [15:0] memory_data;
  logic        data_valid_n, system_enable_n, trigger_out_n, busy_n, cmd_error_n;
  logic [7:0]  control_state;
  int          passed;
  int          total;

  actuator_sequencer_if #(.DATA_W(16), .ADDR_W(8)) mem_bus();

  // Memory read data is a pure function of the address so expected words are known.
  assign mem_bus.memory_data_in = {8'hA5, mem_bus.memory_address};

  actuator_sequencer #(.DATA_W(16), .ADDR_W(8), .CNT_W(32), .TRIG_PULSE(2)) dut (
    .clock(clock), .reset_n(reset_n), .latch_data_sn(latch_data_sn), .cmd_word(cmd_word),
    .refresh_period(refresh_period), .update_done(update_done), .trigger_in_sn(trigger_in_sn),
    .mem_bus(mem_bus), .memory_data(memory_data), .data_valid_n(data_valid_n),
    .system_enable_n(system_enable_n), .trigger_out_n(trigger_out_n), .busy_n(busy_n),
    .cmd_error_n(cmd_error_n), .control_state(control_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Strobe low for one sampled edge; returns at the negedge of the first cycle after acceptance.
  task automatic send_cmd(input logic [7:0] op, input logic [7:0] addr, input logic [15:0] data);
    cmd_word = {op, addr, data};
    latch_data_sn = 1'b0;
    @(negedge clock);
    latch_data_sn = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; latch_data_sn = 1'b0; cmd_word = {8'h01, 8'h33, 16'h0000};
    refresh_period = 32'd0; update_done = 1'b0; trigger_in_sn = 1'b1;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    total++; if (mem_bus.memory_enable_n !== 1'b1) $display("FAIL reset_enable_n: got %b want 1", mem_bus.memory_enable_n); else passed++;
    total++; if (mem_bus.memory_read_n !== 1'b1) $display("FAIL reset_read_n: got %b want 1", mem_bus.memory_read_n); else passed++;
    total++; if (mem_bus.memory_write_n !== 1'b1) $display("FAIL reset_write_n: got %b want 1", mem_bus.memory_write_n); else passed++;
    total++; if (mem_bus.memory_address !== 8'h00) $display("FAIL reset_address: got %h want 00", mem_bus.memory_address); else passed++;
    total++; if (mem_bus.memory_data_out !== 16'h0000) $display("FAIL reset_data_out: got %h want 0000", mem_bus.memory_data_out); else passed++;
    total++; if (memory_data !== 16'h0000) $display("FAIL reset_memory_data: got %h want 0000", memory_data); else passed++;
    total++; if ({data_valid_n, system_enable_n, trigger_out_n, cmd_error_n} !== 4'b1111) $display("FAIL reset_flags_n: got %b want 1111", {data_valid_n, system_enable_n, trigger_out_n, cmd_error_n}); else passed++;
    total++; if (busy_n !== 1'b1) $display("FAIL reset_held_strobe_busy: got %b want 1", busy_n); else passed++;
    total++; if (control_state !== 8'h00) $display("FAIL reset_held_strobe_ctrl: got %h want 00", control_state); else passed++;
    latch_data_sn = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_read_burst();
    logic [7:0]  addrs[$];
    int          acc_cyc[$];
    int          dv_cyc[$];
    logic [15:0] dv_data[$];
    int          busy_low = 0;
    int          wr_seen = 0;
    @(negedge clock);
    send_cmd(8'h21, 8'hFF, 16'h0000);
    for (int c = 1; c <= 8; c++) begin
      if (c != 1) @(negedge clock);
      if (c == 1) begin
        total++; if (control_state !== 8'h21) $display("FAIL rd_control_state: got %h want 21", control_state); else passed++;
      end
      if (!mem_bus.memory_read_n && !mem_bus.memory_enable_n) begin addrs.push_back(mem_bus.memory_address); acc_cyc.push_back(c); end
      if (!data_valid_n) begin dv_cyc.push_back(c); dv_data.push_back(memory_data); end
      if (!busy_n) busy_low++;
      if (!mem_bus.memory_write_n) wr_seen++;
    end
    total++; if (acc_cyc.size() != 2) $display("FAIL rd_strobe_count: got %0d want 2", acc_cyc.size()); else passed++;
    total++; if (addrs[0] !== 8'hFF || addrs[1] !== 8'h00) $display("FAIL rd_addresses: got %h,%h want ff,00", addrs[0], addrs[1]); else passed++;
    total++; if (acc_cyc[0] != 1 || acc_cyc[1] != 4) $display("FAIL rd_strobe_cycles: got %0d,%0d want 1,4", acc_cyc[0], acc_cyc[1]); else passed++;
    total++; if (dv_cyc.size() != 2) $display("FAIL rd_valid_count: got %0d want 2", dv_cyc.size()); else passed++;
    total++; if (dv_cyc[0] != 3 || dv_cyc[1] != 6) $display("FAIL rd_valid_cycles: got %0d,%0d want 3,6", dv_cyc[0], dv_cyc[1]); else passed++;
    total++; if (dv_data[0] !== 16'hA5FF || dv_data[1] !== 16'hA500) $display("FAIL rd_valid_data: got %h,%h want a5ff,a500", dv_data[0], dv_data[1]); else passed++;
    total++; if (memory_data !== 16'hA500) $display("FAIL rd_last_word: got %h want a500", memory_data); else passed++;
    total++; if (busy_low != 6) $display("FAIL rd_busy_cycles: got %0d want 6", busy_low); else passed++;
    total++; if (wr_seen != 0) $display("FAIL rd_no_write: got %0d want 0", wr_seen); else passed++;
  endtask

  task automatic test_write_fill();
    logic [7:0]  addrs[$];
    int          wr_cyc[$];
    logic [15:0] wr_data[$];
    int          busy_low = 0;
    int          rd_seen = 0;
    @(negedge clock);
    send_cmd(8'h42, 8'h10, 16'hBEEF);
    for (int c = 1; c <= 8; c++) begin
      if (c != 1) @(negedge clock);
      if (!mem_bus.memory_write_n && !mem_bus.memory_enable_n) begin
        addrs.push_back(mem_bus.memory_address); wr_cyc.push_back(c); wr_data.push_back(mem_bus.memory_data_out);
      end
      if (!busy_n) busy_low++;
      if (!mem_bus.memory_read_n) rd_seen++;
    end
    total++; if (wr_cyc.size() != 3) $display("FAIL wr_strobe_count: got %0d want 3", wr_cyc.size()); else passed++;
    total++; if (addrs[0] !== 8'h10 || addrs[1] !== 8'h11 || addrs[2] !== 8'h12) $display("FAIL wr_addresses: got %h,%h,%h want 10,11,12", addrs[0], addrs[1], addrs[2]); else passed++;
    total++; if (wr_cyc[0] != 1 || wr_cyc[1] != 3 || wr_cyc[2] != 5) $display("FAIL wr_strobe_cycles: got %0d,%0d,%0d want 1,3,5", wr_cyc[0], wr_cyc[1], wr_cyc[2]); else passed++;
    total++; if (wr_data[0] !== 16'hBEEF || wr_data[1] !== 16'hBEEF || wr_data[2] !== 16'hBEEF) $display("FAIL wr_data: got %h,%h,%h want beef", wr_data[0], wr_data[1], wr_data[2]); else passed++;
    total++; if (busy_low != 6) $display("FAIL wr_busy_cycles: got %0d want 6", busy_low); else passed++;
    total++; if (mem_bus.memory_data_out !== 16'hBEEF) $display("FAIL wr_data_hold: got %h want beef", mem_bus.memory_data_out); else passed++;
    total++; if (rd_seen != 0) $display("FAIL wr_no_read: got %0d want 0", rd_seen); else passed++;
  endtask

  task automatic test_back_to_back();
    @(negedge clock);
    send_cmd(8'h02, 8'h20, 16'h1234);
    repeat (2) @(negedge clock);
    total++; if (busy_n !== 1'b1) $display("FAIL b2b_busy_released: got %b want 1", busy_n); else passed++;
    send_cmd(8'h01, 8'h30, 16'h0000);
    total++; if (cmd_error_n !== 1'b1) $display("FAIL b2b_no_error: got %b want 1", cmd_error_n); else passed++;
    total++; if (control_state !== 8'h01) $display("FAIL b2b_control_state: got %h want 01", control_state); else passed++;
    total++; if (mem_bus.memory_read_n !== 1'b0 || mem_bus.memory_address !== 8'h30) $display("FAIL b2b_read_start: got read_n=%b addr=%h want 0,30", mem_bus.memory_read_n, mem_bus.memory_address); else passed++;
    repeat (3) @(negedge clock);
    total++; if (busy_n !== 1'b1 || memory_data !== 16'hA530) $display("FAIL b2b_read_done: got busy_n=%b data=%h want 1,a530", busy_n, memory_data); else passed++;
  endtask

  task automatic test_cmd_drop();
    @(negedge clock);
    send_cmd(8'h01, 8'h40, 16'h0000);
    @(negedge clock);
    send_cmd(8'h82, 8'h50, 16'h5555);
    total++; if (cmd_error_n !== 1'b0) $display("FAIL drop_error_pulse: got %b want 0", cmd_error_n); else passed++;
    total++; if (control_state !== 8'h01) $display("FAIL drop_control_state: got %h want 01", control_state); else passed++;
    total++; if (data_valid_n !== 1'b0 || memory_data !== 16'hA540) $display("FAIL drop_read_completes: got dv_n=%b data=%h want 0,a540", data_valid_n, memory_data); else passed++;
    @(negedge clock);
    total++; if (cmd_error_n !== 1'b1) $display("FAIL drop_error_width: got %b want 1", cmd_error_n); else passed++;
    total++; if (busy_n !== 1'b1 || mem_bus.memory_write_n !== 1'b1) $display("FAIL drop_no_access: got busy_n=%b write_n=%b want 1,1", busy_n, mem_bus.memory_write_n); else passed++;
  endtask

  task automatic test_refresh(input int period, input int done_age, input int ncyc,
                              input int exp_interval, input int exp_trig_lows);
    int entries[$];
    int trig_idx[$];
    int last_entry = 0;
    int exp_runs;
    logic prev_en = 1'b1;
    refresh_period = period;
    @(negedge clock);
    send_cmd(8'h14, 8'h00, 16'h0000);
    total++; if (system_enable_n !== 1'b1) $display("FAIL refresh_idle_after_load: got %b want 1", system_enable_n); else passed++;
    @(negedge clock);
    for (int c = 0; c < ncyc; c++) begin
      if (c != 0) @(negedge clock);
      if (!trigger_out_n) trig_idx.push_back(c);
      if (!system_enable_n) begin
        if (prev_en) begin entries.push_back(c); last_entry = c; end
        update_done = ((c - last_entry) == done_age);
      end else begin
        update_done = 1'b0;
      end
      prev_en = system_enable_n;
    end
    update_done = 1'b0;
    exp_runs = (ncyc - 1) / exp_interval + 1;
    total++; if (entries.size() != exp_runs) $display("FAIL refresh_run_count p=%0d: got %0d want %0d", period, entries.size(), exp_runs); else passed++;
    for (int k = 0; k < exp_runs; k++) begin
      total++; if (entries[k] != k * exp_interval) $display("FAIL refresh_run_entry p=%0d k=%0d: got %0d want %0d", period, k, entries[k], k * exp_interval); else passed++;
    end
    total++; if (trig_idx.size() != exp_trig_lows) $display("FAIL refresh_trig_lows p=%0d: got %0d want %0d", period, trig_idx.size(), exp_trig_lows); else passed++;
    total++; if (trig_idx[0] != done_age + 1) $display("FAIL refresh_trig_first p=%0d: got %0d want %0d", period, trig_idx[0], done_age + 1); else passed++;
    send_cmd(8'h10, 8'h00, 16'h0000);
    total++; if (system_enable_n !== 1'b1) $display("FAIL refresh_off: got %b want 1", system_enable_n); else passed++;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_triggered();
    int rerun = 0;
    trigger_in_sn = 1'b1;
    @(negedge clock);
    send_cmd(8'h18, 8'h00, 16'h0000);
    repeat (2) @(negedge clock);
    total++; if (system_enable_n !== 1'b1) $display("FAIL trig_armed_idle: got %b want 1", system_enable_n); else passed++;
    trigger_in_sn = 1'b0;
    @(negedge clock);
    trigger_in_sn = 1'b1;
    total++; if (system_enable_n !== 1'b0) $display("FAIL trig_run: got %b want 0", system_enable_n); else passed++;
    update_done = 1'b1;
    @(negedge clock);
    update_done = 1'b0;
    total++; if (system_enable_n !== 1'b1 || trigger_out_n !== 1'b0) $display("FAIL trig_complete: got en_n=%b trig_n=%b want 1,0", system_enable_n, trigger_out_n); else passed++;
    @(negedge clock);
    total++; if (trigger_out_n !== 1'b0) $display("FAIL trig_pulse_second: got %b want 0", trigger_out_n); else passed++;
    @(negedge clock);
    total++; if (trigger_out_n !== 1'b1 || system_enable_n !== 1'b1) $display("FAIL trig_pulse_end: got trig_n=%b en_n=%b want 1,1", trigger_out_n, system_enable_n); else passed++;
    trigger_in_sn = 1'b0;
    @(negedge clock);
    total++; if (system_enable_n !== 1'b0) $display("FAIL trig_held_run: got %b want 0", system_enable_n); else passed++;
    update_done = 1'b1;
    @(negedge clock);
    update_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clock);
      if (!system_enable_n) rerun++;
    end
    total++; if (rerun != 0) $display("FAIL trig_held_no_rerun: got %0d run cycles want 0", rerun); else passed++;
    trigger_in_sn = 1'b1;
    @(negedge clock);
    total++; if (system_enable_n !== 1'b1) $display("FAIL trig_rearm_idle: got %b want 1", system_enable_n); else passed++;
    trigger_in_sn = 1'b0;
    @(negedge clock);
    total++; if (system_enable_n !== 1'b0) $display("FAIL trig_rearm_run: got %b want 0", system_enable_n); else passed++;
    trigger_in_sn = 1'b1;
    update_done = 1'b1;
    send_cmd(8'h18, 8'h00, 16'h0000);
    update_done = 1'b0;
    total++; if (trigger_out_n !== 1'b1 || system_enable_n !== 1'b1) $display("FAIL trig_load_priority: got trig_n=%b en_n=%b want 1,1", trigger_out_n, system_enable_n); else passed++;
    @(negedge clock);
    total++; if (trigger_out_n !== 1'b1 || control_state !== 8'h18) $display("FAIL trig_load_priority_after: got trig_n=%b ctrl=%h want 1,18", trigger_out_n, control_state); else passed++;
  endtask

  task automatic test_single();
    int runs = 0;
    @(negedge clock);
    send_cmd(8'h1C, 8'h00, 16'h0000);
    @(negedge clock);
    total++; if (system_enable_n !== 1'b0) $display("FAIL single_run: got %b want 0", system_enable_n); else passed++;
    update_done = 1'b1;
    @(negedge clock);
    update_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (!system_enable_n) runs++;
    end
    total++; if (runs != 0) $display("FAIL single_done_held: got %0d run cycles want 0", runs); else passed++;
    send_cmd(8'h1C, 8'h00, 16'h0000);
    @(negedge clock);
    total++; if (system_enable_n !== 1'b0) $display("FAIL single_reload_run: got %b want 0", system_enable_n); else passed++;
    send_cmd(8'h10, 8'h00, 16'h0000);
    repeat (3) @(negedge clock);
  endtask

  task automatic test_reset_mid_burst();
    int strobes = 0;
    @(negedge clock);
    send_cmd(8'hE1, 8'h00, 16'h0000);
    repeat (3) @(negedge clock);
    total++; if (mem_bus.memory_read_n !== 1'b0 || mem_bus.memory_address !== 8'h01) $display("FAIL rst_burst_second_word: got read_n=%b addr=%h want 0,01", mem_bus.memory_read_n, mem_bus.memory_address); else passed++;
    reset_n = 1'b0;
    @(negedge clock);
    total++; if ({mem_bus.memory_enable_n, mem_bus.memory_read_n, mem_bus.memory_write_n} !== 3'b111) $display("FAIL rst_mid_strobes: got %b want 111", {mem_bus.memory_enable_n, mem_bus.memory_read_n, mem_bus.memory_write_n}); else passed++;
    total++; if (memory_data !== 16'h0000) $display("FAIL rst_mid_memory_data: got %h want 0000", memory_data); else passed++;
    total++; if (busy_n !== 1'b1 || data_valid_n !== 1'b1) $display("FAIL rst_mid_busy_dv: got busy_n=%b dv_n=%b want 1,1", busy_n, data_valid_n); else passed++;
    total++; if (control_state !== 8'h00 || mem_bus.memory_address !== 8'h00) $display("FAIL rst_mid_regs: got ctrl=%h addr=%h want 00,00", control_state, mem_bus.memory_address); else passed++;
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (!mem_bus.memory_enable_n) strobes++;
    end
    total++; if (strobes != 0) $display("FAIL rst_mid_no_resume: got %0d strobes want 0", strobes); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_read_burst();
    test_write_fill();
    test_back_to_back();
    test_cmd_drop();
    test_refresh(5, 3, 23, 10, 4);
    test_refresh(0, 0, 7, 2, 6);
    test_triggered();
    test_single();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
